wb_ram_responder: RTL and testbench

// - Wishbone-style responder (slave) for the single-strobe bus driven by the RAM test controller.
// - Owns a single-port word RAM and answers every cycle/strobe with exactly one ack pulse.
// - Inserts a configurable number of wait states.
// - Replaces the ad-hoc toggle-ack RAM in test tops; sits between one bus initiator and on-chip block RAM.

---
 rtl/wb_ram_responder_pkg.sv | 27 ++
 rtl/wb_ram_responder_if.sv | 30 +++
 rtl/wb_ram_responder_ram_array.sv | 30 +++
 rtl/wb_ram_responder.sv | 136 +++++++++++++
 tb/tb_wb_ram_responder.sv | 369 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_ram_responder_pkg.sv
// Shared definitions for the Wishbone RAM responder: bus widths, FSM states
// and the wait-state counter sizing.
package wb_ram_responder_pkg;

    localparam int WB_DATA_WIDTH = 32;
    localparam int WB_ADDR_WIDTH = 32;
    localparam int WB_CNT_WIDTH  = 4;
    localparam int WB_MAX_WAIT   = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } wb_state_e;

    // Out-of-range wait settings saturate rather than wrap the 4-bit counter.
    function automatic logic [WB_CNT_WIDTH-1:0] wait_load(input int cycles);
        if (cycles > WB_MAX_WAIT) begin
            return WB_CNT_WIDTH'(WB_MAX_WAIT);
        end
        if (cycles < 0) begin
            return '0;
        end
        return WB_CNT_WIDTH'(cycles);
    endfunction

endpackage

// File: rtl/wb_ram_responder_if.sv
// Single-strobe Wishbone-style bus between one initiator and the RAM responder.
interface wb_ram_responder_if;
    import wb_ram_responder_pkg::*;

    logic                     wb_cycle_strobe;
    logic                     wb_write_enable;
    logic [WB_ADDR_WIDTH-1:0] wb_address;
    logic [WB_DATA_WIDTH-1:0] wb_write_data;
    logic [WB_DATA_WIDTH-1:0] wb_read_data;
    logic                     wb_ack;

    modport master (
        output wb_cycle_strobe,
        output wb_write_enable,
        output wb_address,
        output wb_write_data,
        input  wb_read_data,
        input  wb_ack
    );

    modport slave (
        input  wb_cycle_strobe,
        input  wb_write_enable,
        input  wb_address,
        input  wb_write_data,
        output wb_read_data,
        output wb_ack
    );

endinterface

// File: rtl/wb_ram_responder_ram_array.sv
// Single-port synchronous word RAM with a registered read port; no reset so
// it maps onto block RAM.
module wb_ram_responder_ram_array #(
    parameter int ADDR_BITS  = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_BITS-1:0]  addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_BITS)-1];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Read output only moves on a read strobe, so it holds between read accesses.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/wb_ram_responder.sv
// Wishbone-style RAM responder: captures each strobe, inserts WAIT_CYCLES wait
// states, then performs the RAM access and returns a single registered ack.
module wb_ram_responder
    import wb_ram_responder_pkg::*;
#(
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                pinClock,
    input  logic                pinResetN,
    wb_ram_responder_if.slave   bus
);

    localparam logic [WB_CNT_WIDTH-1:0] WAIT_LOAD = wait_load(WAIT_CYCLES);

    wb_state_e                state_q, state_d;
    logic [WB_CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                     ack_q, ack_d;
    logic                     rd_valid_q, rd_valid_d;
    logic                     we_q, we_d;
    logic [ADDR_BITS-1:0]     adr_q, adr_d;
    logic [WB_DATA_WIDTH-1:0] dat_q, dat_d;

    logic                     go_ack;
    logic                     acc_we;
    logic                     ram_we;
    logic                     ram_re;
    logic [ADDR_BITS-1:0]     ram_addr;
    logic [WB_DATA_WIDTH-1:0] ram_wdata;
    logic [WB_DATA_WIDTH-1:0] ram_rdata;

    logic                     adr_unused;
    assign adr_unused = ^bus.wb_address[WB_ADDR_WIDTH-1:ADDR_BITS];

    // With zero wait states the access happens on the capture edge itself, so
    // the RAM is fed from the live bus in IDLE and from the captured copy after.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ack_d      = 1'b0;
        rd_valid_d = rd_valid_q;
        we_d       = we_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        go_ack     = 1'b0;
        acc_we     = we_q;
        ram_addr   = adr_q;
        ram_wdata  = dat_q;
        ram_we     = 1'b0;
        ram_re     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                acc_we    = bus.wb_write_enable;
                ram_addr  = bus.wb_address[ADDR_BITS-1:0];
                ram_wdata = bus.wb_write_data;
                if (bus.wb_cycle_strobe) begin
                    we_d  = bus.wb_write_enable;
                    adr_d = bus.wb_address[ADDR_BITS-1:0];
                    dat_d = bus.wb_write_data;
                    if (WAIT_LOAD == '0) begin
                        go_ack = 1'b1;
                    end else begin
                        cnt_d   = WAIT_LOAD;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (bus.wb_cycle_strobe) begin
                    cnt_d = cnt_q - WB_CNT_WIDTH'(1);
                    if (cnt_q == WB_CNT_WIDTH'(1)) begin
                        go_ack = 1'b1;
                    end
                end else begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (go_ack) begin
            state_d = ST_ACK;
            ack_d   = 1'b1;
            ram_we  = acc_we;
            ram_re  = !acc_we;
            if (!acc_we) begin
                rd_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge pinClock or negedge pinResetN) begin
        if (!pinResetN) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            ack_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            we_q       <= 1'b0;
            adr_q      <= '0;
            dat_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ack_q      <= ack_d;
            rd_valid_q <= rd_valid_d;
            we_q       <= we_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
        end
    end

    wb_ram_responder_ram_array #(
        .ADDR_BITS  (ADDR_BITS),
        .DATA_WIDTH (WB_DATA_WIDTH)
    ) u_ram (
        .clk   (pinClock),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // The RAM output register has no reset; rd_valid_q forces zero until the
    // first read after reset.
    assign bus.wb_read_data = rd_valid_q ? ram_rdata : '0;
    assign bus.wb_ack       = ack_q;

endmodule

// File: tb/tb_wb_ram_responder.sv
// Directed bench for wb_ram_responder: one instance with no wait states and
// one with three, sharing clock and reset.
module tb_wb_ram_responder;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    wb_ram_responder_if bus0();
    wb_ram_responder_if bus3();

    wb_ram_responder #(.ADDR_BITS(8), .WAIT_CYCLES(0)) dut0 (
        .pinClock  (clk),
        .pinResetN (rst_n),
        .bus       (bus0)
    );

    wb_ram_responder #(.ADDR_BITS(8), .WAIT_CYCLES(3)) dut3 (
        .pinClock  (clk),
        .pinResetN (rst_n),
        .bus       (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-cycle protocol watch: no double-length ack, no ack without a strobe.
    logic stb_edge0, stb_edge3, ack_prev0, ack_prev3;
    initial begin
        stb_edge0 = 1'b0;
        stb_edge3 = 1'b0;
        ack_prev0 = 1'b0;
        ack_prev3 = 1'b0;
    end

    always @(posedge clk) begin
        stb_edge0 <= bus0.wb_cycle_strobe;
        stb_edge3 <= bus3.wb_cycle_strobe;
    end

    always @(negedge clk) begin
        if (rst_n && bus0.wb_ack) begin
            n_checks++;
            if (ack_prev0 || !stb_edge0) begin
                n_errors++;
                $display("[TB] FAIL mon0_ack got prev_ack=%0b strobe_at_edge=%0b want prev_ack=0 strobe_at_edge=1", ack_prev0, stb_edge0);
            end
        end
        if (rst_n && bus3.wb_ack) begin
            n_checks++;
            if (ack_prev3 || !stb_edge3) begin
                n_errors++;
                $display("[TB] FAIL mon3_ack got prev_ack=%0b strobe_at_edge=%0b want prev_ack=0 strobe_at_edge=1", ack_prev3, stb_edge3);
            end
        end
        ack_prev0 <= rst_n & bus0.wb_ack;
        ack_prev3 <= rst_n & bus3.wb_ack;
    end

    task automatic drive(input bit on3, input logic stb, input logic we,
                         input logic [31:0] adr, input logic [31:0] dat);
        if (on3) begin
            bus3.wb_cycle_strobe = stb;
            bus3.wb_write_enable = we;
            bus3.wb_address      = adr;
            bus3.wb_write_data   = dat;
        end else begin
            bus0.wb_cycle_strobe = stb;
            bus0.wb_write_enable = we;
            bus0.wb_address      = adr;
            bus0.wb_write_data   = dat;
        end
    endtask

    function automatic logic ack_of(input bit on3);
        return on3 ? bus3.wb_ack : bus0.wb_ack;
    endfunction

    function automatic logic [31:0] rdata_of(input bit on3);
        return on3 ? bus3.wb_read_data : bus0.wb_read_data;
    endfunction

    // One complete access; lat counts sampling points from strobe to ack.
    // Leaves one idle cycle afterwards so the next access starts from IDLE.
    task automatic bus_access(input bit on3, input logic wr, input logic [31:0] adr,
                              input logic [31:0] dat, input bit scramble,
                              output logic [31:0] rdat, output int lat);
        bit got;
        got  = 1'b0;
        lat  = -1;
        rdat = 32'hxxxx_xxxx;
        drive(on3, 1'b1, wr, adr, dat);
        for (int k = 1; k <= 20 && !got; k++) begin
            @(negedge clk);
            if (ack_of(on3)) begin
                got  = 1'b1;
                lat  = k;
                rdat = rdata_of(on3);
            end else if (scramble) begin
                drive(on3, 1'b1, ~wr, ~adr, ~dat);
            end
        end
        drive(on3, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        if (!got) begin
            n_checks++;
            n_errors++;
            $display("[TB] FAIL access_timeout dut%0d adr=%h got no ack want ack within 20 cycles", on3 ? 3 : 0, adr);
        end
    endtask

    task automatic test_reset();
        bit saw;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus0.wb_ack !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL reset_ack0 got %b want 0", bus0.wb_ack);
        end
        n_checks++;
        if (bus3.wb_ack !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL reset_ack3 got %b want 0", bus3.wb_ack);
        end
        n_checks++;
        if (bus0.wb_read_data !== 32'h0) begin
            n_errors++;
            $display("[TB] FAIL reset_rdata0 got %h want 00000000", bus0.wb_read_data);
        end
        n_checks++;
        if (bus3.wb_read_data !== 32'h0) begin
            n_errors++;
            $display("[TB] FAIL reset_rdata3 got %h want 00000000", bus3.wb_read_data);
        end
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus0.wb_ack !== 1'b0 || bus3.wb_ack !== 1'b0) saw = 1'b1;
        end
        n_checks++;
        if (saw !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL idle_no_ack got ack=1 want no ack with strobe low");
        end
    endtask

    task automatic test_w0_write_read();
        logic [31:0] rd;
        int lat;
        bus_access(1'b0, 1'b1, 32'h05, 32'hDEADBEEF, 1'b0, rd, lat);
        n_checks++;
        if (lat !== 1) begin
            n_errors++;
            $display("[TB] FAIL w0_write_latency got %0d want 1", lat);
        end
        bus_access(1'b0, 1'b0, 32'h05, 32'h0, 1'b0, rd, lat);
        n_checks++;
        if (lat !== 1) begin
            n_errors++;
            $display("[TB] FAIL w0_read_latency got %0d want 1", lat);
        end
        n_checks++;
        if (rd !== 32'hDEADBEEF) begin
            n_errors++;
            $display("[TB] FAIL w0_read_data got %h want deadbeef", rd);
        end
        // A write must not disturb the held read data.
        bus_access(1'b0, 1'b1, 32'h06, 32'h11111111, 1'b0, rd, lat);
        n_checks++;
        if (bus0.wb_read_data !== 32'hDEADBEEF) begin
            n_errors++;
            $display("[TB] FAIL w0_read_hold got %h want deadbeef", bus0.wb_read_data);
        end
    endtask

    task automatic test_w3_read();
        logic [31:0] rd;
        int lat;
        bus_access(1'b1, 1'b1, 32'h10, 32'h12345678, 1'b0, rd, lat);
        n_checks++;
        if (lat !== 4) begin
            n_errors++;
            $display("[TB] FAIL w3_write_latency got %0d want 4", lat);
        end
        bus_access(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, rd, lat);
        n_checks++;
        if (lat !== 4) begin
            n_errors++;
            $display("[TB] FAIL w3_read_latency got %0d want 4", lat);
        end
        n_checks++;
        if (rd !== 32'h12345678) begin
            n_errors++;
            $display("[TB] FAIL w3_read_data got %h want 12345678", rd);
        end
        n_checks++;
        if (bus3.wb_ack !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL w3_ack_width got %b want 0 one cycle after ack", bus3.wb_ack);
        end
    endtask

    task automatic test_w3_captured();
        logic [31:0] rd;
        int lat;
        bus_access(1'b1, 1'b1, 32'h30, 32'hCAFEF00D, 1'b1, rd, lat);
        n_checks++;
        if (lat !== 4) begin
            n_errors++;
            $display("[TB] FAIL capture_write_latency got %0d want 4", lat);
        end
        bus_access(1'b1, 1'b0, 32'h30, 32'h0, 1'b0, rd, lat);
        n_checks++;
        if (rd !== 32'hCAFEF00D) begin
            n_errors++;
            $display("[TB] FAIL capture_read_data got %h want cafef00d", rd);
        end
    endtask

    task automatic test_back_to_back(input bit on3, input logic [31:0] adr,
                                     input logic [31:0] exp_data,
                                     input int exp_first, input int exp_gap);
        int hits[3];
        int n;
        logic [31:0] d0;
        n  = 0;
        d0 = 32'h0;
        for (int i = 0; i < 3; i++) hits[i] = -100;
        drive(on3, 1'b1, 1'b0, adr, 32'h0);
        for (int k = 1; k <= 40 && n < 3; k++) begin
            @(negedge clk);
            if (ack_of(on3)) begin
                if (n == 0) d0 = rdata_of(on3);
                hits[n] = k;
                n++;
            end
        end
        drive(on3, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        n_checks++;
        if (n !== 3) begin
            n_errors++;
            $display("[TB] FAIL b2b%0d_count got %0d want 3", on3 ? 3 : 0, n);
        end
        n_checks++;
        if (hits[0] !== exp_first) begin
            n_errors++;
            $display("[TB] FAIL b2b%0d_first got %0d want %0d", on3 ? 3 : 0, hits[0], exp_first);
        end
        n_checks++;
        if (hits[1] - hits[0] !== exp_gap || hits[2] - hits[1] !== exp_gap) begin
            n_errors++;
            $display("[TB] FAIL b2b%0d_spacing got %0d,%0d want %0d", on3 ? 3 : 0,
                     hits[1] - hits[0], hits[2] - hits[1], exp_gap);
        end
        n_checks++;
        if (d0 !== exp_data) begin
            n_errors++;
            $display("[TB] FAIL b2b%0d_data got %h want %h", on3 ? 3 : 0, d0, exp_data);
        end
    endtask

    task automatic test_alias();
        logic [31:0] rd;
        int lat;
        bus_access(1'b0, 1'b1, 32'h00000105, 32'hA5A5A5A5, 1'b0, rd, lat);
        bus_access(1'b0, 1'b0, 32'h00000005, 32'h0, 1'b0, rd, lat);
        n_checks++;
        if (rd !== 32'hA5A5A5A5) begin
            n_errors++;
            $display("[TB] FAIL alias_read got %h want a5a5a5a5", rd);
        end
    endtask

    task automatic test_abort();
        logic [31:0] rd;
        int lat;
        bit saw;
        bus_access(1'b1, 1'b1, 32'h20, 32'h0BADF00D, 1'b0, rd, lat);
        saw = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 32'h20, 32'h1);
        repeat (2) begin
            @(negedge clk);
            if (bus3.wb_ack !== 1'b0) saw = 1'b1;
        end
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (5) begin
            @(negedge clk);
            if (bus3.wb_ack !== 1'b0) saw = 1'b1;
        end
        n_checks++;
        if (saw !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL abort_no_ack got ack=1 want no ack");
        end
        n_checks++;
        if (bus3.wb_read_data !== 32'h12345678) begin
            n_errors++;
            $display("[TB] FAIL abort_rdata_hold got %h want 12345678", bus3.wb_read_data);
        end
        bus_access(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, rd, lat);
        n_checks++;
        if (rd !== 32'h0BADF00D) begin
            n_errors++;
            $display("[TB] FAIL abort_old_value got %h want 0badf00d", rd);
        end
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] rd;
        int lat;
        bit saw;
        bus_access(1'b1, 1'b1, 32'h40, 32'h77777777, 1'b0, rd, lat);
        saw = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 32'h40, 32'h88888888);
        repeat (2) begin
            @(negedge clk);
            if (bus3.wb_ack !== 1'b0) saw = 1'b1;
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus3.wb_read_data !== 32'h0) begin
            n_errors++;
            $display("[TB] FAIL rstwait_rdata got %h want 00000000", bus3.wb_read_data);
        end
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (bus3.wb_ack !== 1'b0) saw = 1'b1;
        end
        n_checks++;
        if (saw !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL rstwait_no_ack got ack=1 want no ack");
        end
        bus_access(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, rd, lat);
        n_checks++;
        if (rd !== 32'h77777777 || lat !== 4) begin
            n_errors++;
            $display("[TB] FAIL rstwait_discarded got data=%h lat=%0d want data=77777777 lat=4", rd, lat);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        test_reset();
        test_w0_write_read();
        test_w3_read();
        test_w3_captured();
        test_back_to_back(1'b0, 32'h05, 32'hDEADBEEF, 1, 2);
        test_back_to_back(1'b1, 32'h10, 32'h12345678, 4, 5);
        test_alias();
        test_abort();
        test_reset_in_wait();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
